axis_arb_mux: RTL
=================

# axis_arb_mux

Packet-aware N-to-1 AXI-Stream multiplexer with internal round-robin arbitration and a registered output stage. It generalises the combinational 2-to-1 select mux to N channels. Channel selection comes from an internal arbiter, and a granted channel stays selected until its `last` beat is accepted, so packets never interleave. It sits where several stream producers share one downstream consumer.

## Interface
Parameters:
- `WIDTH`, 4, data width of each channel in bits.
- `N`, 4, number of input channels; legal range 2..16.
- `GW`, $clog2(N), derived width of the grant index; not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assertion, active-low.
- `s_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `s_valid`  in  N  per-channel valid.
- `s_last`  in  N  per-channel end-of-packet marker.
- `s_ready`  out  N  per-channel ready; at most one bit is high.
- `m_data`  out  WIDTH  registered output data.
- `m_valid`  out  1  registered output valid.
- `m_last`  out  1  registered output last.
- `m_ready`  in  1  downstream ready.
- `grant`  out  GW  index of the currently or most recently locked channel.
- `busy`  out  1  high while the block is in the LOCK state.

## Operation
- Handshake: a beat transfers on any edge where valid && ready, on both input and output sides.
- State machine has two states, IDLE and LOCK.
- IDLE:
  - The arbiter searches `s_valid` round-robin, starting at index (ptr+1) mod N and wrapping.
  - If any channel is valid, the first hit is registered into `grant` and the state moves to LOCK.
  - All `s_ready` bits are 0.
- LOCK:
  - `s_ready[grant]` = !m_valid || m_ready. All other `s_ready` bits are 0.
  - On an input transfer, `s_data`/`s_last` of the granted channel load into `m_data`/`m_last`, and `m_valid` is set.
  - On an accepted input beat with `s_last[grant]`=1, ptr <= grant and the state returns to IDLE.
- Output register:
  - On an output transfer with no new load, `m_valid` clears.
  - A load and an output transfer in the same cycle leaves `m_valid`=1, holding the new beat.
- `m_data`/`m_last` hold their value while `m_valid`=1 && `m_ready`=0.
- Valid inputs on non-granted channels are ignored until the lock releases. The block never drops or reorders beats.
- A single-beat packet (`last` on the first beat) is legal: one LOCK cycle, then back to IDLE.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `s_ready`=0, `grant`=0, `busy`=0, state=IDLE, ptr=N-1 (channel 0 has first priority).
- Reset asserted mid-packet:
  - All outputs return to their reset values immediately.
  - Any beat held in the output register is discarded.
- Arbitration latency: a valid arriving while IDLE gets `s_ready` high on the next cycle.
- Data latency: the first beat appears on `m_*` one cycle after its input transfer.
- Throughput:
  - One beat per cycle within a packet while `m_ready`=1.
  - One idle (arbitration) cycle between consecutive packets.
- `s_ready` depends combinationally on `m_ready`. No other combinational input-to-output path exists.
- Channel valid dropping while IDLE before a grant is taken: no grant, no effect.
- When a grant is taken, the producer must hold valid per the standard stream rules.

## Configuration
- `AXIS_ARB_MUX_PRIORITY_EN`:
  - Defined: fixed-priority arbitration. The IDLE search always starts at index 0 (lowest index wins), and ptr is unused.
  - Undefined (default): round-robin as described in Operation.
- Packet locking and timing are identical in both builds.

## Test plan
- Reset with all `s_valid`=1 -> `m_valid`=0 and `s_ready`=0 during reset. The first grant is channel 0, with `s_ready`=4'b0001 two cycles after `rst_n` rises (N=4).
- Channels 0..3 each stream continuously with 3-beat packets, `m_ready`=1 -> output packet order is 0,1,2,3,0..., no interleaving, 3 beats then 1 bubble per packet. With PRIORITY_EN the order is 0,0,0...
- Channel 2 sends data 0xA,0xB,0xC (last on 0xC) with `m_ready` toggling 1,0,0,1,1,0,1 -> output beats are exactly 0xA,0xB,0xC, held stable during stalls, `m_last` only with 0xC.
- Channel 1 sends a single-beat packet while channel 3 is valid -> grant goes 1 then 3, with `busy` low for exactly one cycle between them.
- `rst_n` asserted on the second beat of a 4-beat packet -> all outputs are at reset values at once. After release, arbitration restarts at channel 0 and no stale beat appears.
- Channel 0 asserts valid for one cycle while IDLE and channel 1 is also valid with ptr=0 -> channel 1 is granted, and channel 0 gets no `s_ready`.

Source files
------------

// File: rtl/axis_arb_mux.sv
// Packet-aware N-to-1 AXI-Stream mux with round-robin arbitration and a registered output stage.
// Define AXIS_ARB_MUX_PRIORITY_EN for fixed-priority arbitration (lowest index wins).
module axis_arb_mux #(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int GW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   s_data,
  input  logic [N-1:0]         s_valid,
  input  logic [N-1:0]         s_last,
  output logic [N-1:0]         s_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic [GW-1:0]        grant,
  output logic                 busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [GW:0] NUM = (GW+1)'(N);

  state_t            state_reg, state_next;
  logic [GW-1:0]     grant_reg, grant_next;
  logic [WIDTH-1:0]  m_data_reg;
  logic              m_valid_reg, m_last_reg;
  logic              sel_ready, take, found;
  logic [GW-1:0]     pick;
  logic [GW:0]       cand;
`ifndef AXIS_ARB_MUX_PRIORITY_EN
  logic [GW-1:0]     ptr_reg, ptr_next;
`endif

  // The granted channel may accept a beat whenever the output register is free or draining.
  assign sel_ready = !m_valid_reg || m_ready;
  assign take      = (state_reg == LOCK) && s_valid[grant_reg] && sel_ready;

  always_comb begin
    s_ready = '0;
    if (state_reg == LOCK) s_ready[grant_reg] = sel_ready;
  end

  // Search for the first valid channel, wrapping modulo N from the starting index.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
`ifdef AXIS_ARB_MUX_PRIORITY_EN
      cand = (GW+1)'(k);
`else
      cand = (GW+1)'(ptr_reg) + (GW+1)'(k) + (GW+1)'(1);
`endif
      if (cand >= NUM) cand = cand - NUM;
      if (!found && s_valid[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
`ifndef AXIS_ARB_MUX_PRIORITY_EN
    ptr_next   = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          state_next = LOCK;
        end
      end
      LOCK: begin
        if (take && s_last[grant_reg]) begin
          state_next = IDLE;
`ifndef AXIS_ARB_MUX_PRIORITY_EN
          ptr_next   = grant_reg;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
`ifndef AXIS_ARB_MUX_PRIORITY_EN
      ptr_reg   <= GW'(N-1);
`endif
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
`ifndef AXIS_ARB_MUX_PRIORITY_EN
      ptr_reg   <= ptr_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_reg  <= '0;
      m_last_reg  <= 1'b0;
      m_valid_reg <= 1'b0;
    end else if (take) begin
      m_data_reg  <= s_data[grant_reg*WIDTH +: WIDTH];
      m_last_reg  <= s_last[grant_reg];
      m_valid_reg <= 1'b1;
    end else if (m_valid_reg && m_ready) begin
      m_valid_reg <= 1'b0;
    end
  end

  assign m_data  = m_data_reg;
  assign m_valid = m_valid_reg;
  assign m_last  = m_last_reg;
  assign grant   = grant_reg;
  assign busy    = (state_reg == LOCK);

endmodule
